// File: rtl/hash_load_ctrl.sv
// hash_load_ctrl: byte-wise loader feeding the target-hash shift register, tracks complete digests
module hash_load_ctrl #(
    parameter int TOTAL_BYTES = 1024,
    parameter int HASH_BYTES  = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load_start,
    input  logic       load_end,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       byte_ready,
    output logic       shift_enable,
    output logic [7:0] serial_out,
    output logic [6:0] hash_count,
    output logic       load_busy,
    output logic       load_done,
    output logic       load_error
);
    localparam int CW = $clog2(TOTAL_BYTES + 1);
    localparam int PW = HASH_BYTES > 1 ? $clog2(HASH_BYTES) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;
    state_t        state;
    logic [CW-1:0] byte_cnt;
    logic [PW-1:0] byte_pos;
    logic [PW-1:0] pos_nxt;
    logic          accept;
    logic          digest_end;
    logic          full_nxt;
    // handshake, digest boundary and end-of-capacity detection; a restart drops any same-cycle byte
    always_comb begin
        load_busy  = state == LOAD;
        byte_ready = load_busy && byte_cnt < CW'(TOTAL_BYTES);
        accept     = byte_valid && byte_ready && !load_start;
        digest_end = accept && byte_pos == PW'(HASH_BYTES - 1);
        pos_nxt    = digest_end ? '0 : byte_pos + PW'(accept);
        full_nxt   = byte_cnt + CW'(accept) == CW'(TOTAL_BYTES);
    end
    // session FSM with registered shift outputs; the accepted byte is counted before load_end is judged
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            byte_pos     <= '0;
            shift_enable <= 1'b0;
            serial_out   <= '0;
            hash_count   <= '0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            shift_enable <= accept;
            if (accept) serial_out <= byte_in;
            if (load_start) begin
                state      <= LOAD;
                byte_cnt   <= '0;
                byte_pos   <= '0;
                hash_count <= '0;
                load_done  <= 1'b0;
                load_error <= 1'b0;
            end else if (state == LOAD) begin
                byte_cnt <= byte_cnt + CW'(accept);
                byte_pos <= pos_nxt;
                if (digest_end) hash_count <= hash_count + 7'd1;
                if (full_nxt || (load_end && pos_nxt == '0)) begin
                    state     <= DONE;
                    load_done <= 1'b1;
                end else if (load_end) begin
                    state      <= ERROR;
                    load_error <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_hash_load_ctrl.sv
// tb_hash_load_ctrl: directed vector table plus multi-cycle sequences for hash_load_ctrl
module tb_hash_load_ctrl;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       load_start = 1'b0;
    logic       load_end = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_ready;
    logic       shift_enable;
    logic [7:0] serial_out;
    logic [6:0] hash_count;
    logic       load_busy;
    logic       load_done;
    logic       load_error;
    int checks = 0;
    int errors = 0;

    hash_load_ctrl dut (
        .clk(clk), .n_rst(n_rst), .load_start(load_start), .load_end(load_end),
        .byte_valid(byte_valid), .byte_in(byte_in), .byte_ready(byte_ready),
        .shift_enable(shift_enable), .serial_out(serial_out), .hash_count(hash_count),
        .load_busy(load_busy), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ls, le, bv;
        logic [7:0] bi;
        logic       se;
        logic [7:0] so;
        logic [6:0] hc;
        logic       busy, done, err, rdy;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic se, input logic [7:0] so, input logic [6:0] hc,
                            input logic busy, input logic done, input logic err, input logic rdy);
        chk({tag, ".shift_enable"}, 32'(shift_enable), 32'(se));
        chk({tag, ".serial_out"}, 32'(serial_out), 32'(so));
        chk({tag, ".hash_count"}, 32'(hash_count), 32'(hc));
        chk({tag, ".load_busy"}, 32'(load_busy), 32'(busy));
        chk({tag, ".load_done"}, 32'(load_done), 32'(done));
        chk({tag, ".load_error"}, 32'(load_error), 32'(err));
        chk({tag, ".byte_ready"}, 32'(byte_ready), 32'(rdy));
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            byte_in = 8'(i);
            step();
        end
        byte_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int se_cnt;
        int cyc;
        int n;
        //             ls le bv bi     se so     hc busy done err rdy
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 8'h00, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 8'h12, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h12, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h34, 1'b1, 8'h34, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h56, 1'b0, 8'h34, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h34, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 8'h34, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h34, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h9A, 1'b1, 8'h9A, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'hBC, 1'b0, 8'h9A, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0};

        #3;
        chk_outs("reset", 1'b0, 8'h00, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        n_rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            load_start = vecs[i].ls;
            load_end   = vecs[i].le;
            byte_valid = vecs[i].bv;
            byte_in    = vecs[i].bi;
            step();
            chk_outs($sformatf("vec%0d", i), vecs[i].se, vecs[i].so, vecs[i].hc,
                     vecs[i].busy, vecs[i].done, vecs[i].err, vecs[i].rdy);
        end
        load_start = 1'b0;
        load_end = 1'b0;
        byte_valid = 1'b0;

        // full 1024-byte load, back-to-back
        pulse_start();
        for (int i = 0; i < 1024; i++) begin
            byte_valid = 1'b1;
            byte_in = 8'(i);
            step();
            chk("full.shift_enable", 32'(shift_enable), 32'd1);
            chk("full.serial_out", 32'(serial_out), 32'(i % 256));
            chk("full.hash_count", 32'(hash_count), 32'((i + 1) / 16));
            chk("full.load_done", 32'(load_done), 32'(i == 1023));
        end
        chk("full.byte_ready_after", 32'(byte_ready), 32'd0);
        step();
        byte_valid = 1'b0;
        chk_outs("full.after", 1'b0, 8'hFF, 7'd64, 1'b0, 1'b1, 1'b0, 1'b0);

        // 48 bytes with random gaps, then load_end
        pulse_start();
        se_cnt = 0;
        n = 0;
        cyc = 0;
        while (n < 48 && cyc < 2000) begin
            byte_valid = 1'($urandom_range(0, 1));
            byte_in = 8'(n);
            if (byte_valid) n++;
            step();
            se_cnt += 32'(shift_enable);
            cyc++;
        end
        chk("gaps.budget", 32'(n), 32'd48);
        byte_valid = 1'b0;
        load_end = 1'b1;
        step();
        load_end = 1'b0;
        se_cnt += 32'(shift_enable);
        chk("gaps.shift_count", 32'(se_cnt), 32'd48);
        chk_outs("gaps.end", 1'b0, 8'd47, 7'd3, 1'b0, 1'b1, 1'b0, 1'b0);

        // partial digest closes in ERROR
        pulse_start();
        send_bytes(20);
        load_end = 1'b1;
        step();
        load_end = 1'b0;
        chk_outs("partial", 1'b0, 8'd19, 7'd1, 1'b0, 1'b0, 1'b1, 1'b0);

        // asynchronous reset mid-load
        pulse_start();
        send_bytes(500);
        chk("mid.hash_count", 32'(hash_count), 32'd31);
        #2;
        n_rst = 1'b0;
        #1;
        chk_outs("async_rst", 1'b0, 8'h00, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        n_rst = 1'b1;
        pulse_start();
        send_bytes(16);
        chk("post_rst.hash_count", 32'(hash_count), 32'd1);
        load_end = 1'b1;
        step();
        load_end = 1'b0;
        chk_outs("post_rst.done", 1'b0, 8'd15, 7'd1, 1'b0, 1'b1, 1'b0, 1'b0);

        // restart from DONE with a byte offered in the same cycle
        load_start = 1'b1;
        byte_valid = 1'b1;
        byte_in = 8'hEE;
        step();
        load_start = 1'b0;
        byte_valid = 1'b0;
        chk_outs("restart", 1'b0, 8'd15, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        chk_outs("restart.idle", 1'b0, 8'd15, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
